// File: rtl/pending_encoder32.sv
// pending_encoder32: sticky multi-hot request capture, serialised as indices over Valid/Ready.
// Define PENDING_ENCODER32_RR_EN for round-robin instead of fixed (bit 0 first) priority.
module pending_encoder32 #(
    parameter int N    = 32,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    In,
    input  logic            Ready,
    input  logic            ClearOvf,
    output logic [IDXW-1:0] Out,
    output logic            Valid,
    output logic [N-1:0]    Pending,
    output logic            Overrun
);
    logic [N-1:0]    pending;
    logic [N-1:0]    clr;
    logic [IDXW-1:0] sel;
    logic            fire;

`ifdef PENDING_ENCODER32_RR_EN
    logic [IDXW-1:0] last;
    logic [IDXW-1:0] base;
    logic [IDXW-1:0] k;
    logic [2*N-1:0]  dbl;

    // Rotate so the search starts at last+1; N is a power of two so index math wraps naturally.
    assign base = last + IDXW'(1);
    assign dbl  = {pending, pending} >> base;

    always_comb begin
        k = '0;
        for (int i = N - 1; i >= 0; i--)
            if (dbl[i]) k = IDXW'(i);
        sel = base + k;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last <= IDXW'(N - 1);
        else if (fire) last <= Out;
`else
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending[i]) sel = IDXW'(i);
    end
`endif

    assign Valid   = |pending;
    assign Out     = Valid ? sel : '0;
    assign Pending = pending;
    assign fire    = Valid & Ready;
    assign clr     = fire ? (N'(1) << Out) : '0;

    // New requests win over the clear, and a hit on a bit that stays pending is lost.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pending <= '0;
            Overrun <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | In;
            Overrun <= (|(In & pending & ~clr)) | (Overrun & ~ClearOvf);
        end
endmodule

// File: tb/tb_pending_encoder32.sv
// tb_pending_encoder32: directed stimulus with a queue of expected indices checked by a monitor.
module tb_pending_encoder32;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] In;
    logic        Ready;
    logic        ClearOvf;
    logic [4:0]  Out;
    logic        Valid;
    logic [31:0] Pending;
    logic        Overrun;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    pending_encoder32 dut (
        .clk(clk), .reset_n(reset_n), .In(In), .Ready(Ready), .ClearOvf(ClearOvf),
        .Out(Out), .Valid(Valid), .Pending(Pending), .Overrun(Overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    // Every accepting cycle must present the next index the stimulus queued.
    always @(negedge clk)
        if (reset_n && Valid && Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: got Out=%0d expected no accept", Out);
            end else
                chk("accept_out", 32'(Out), 32'(exp_q.pop_front()));
        end

    initial begin
        reset_n = 1'b0; In = '0; Ready = 1'b0; ClearOvf = 1'b0;
        #12;
        chk("reset_valid", 32'(Valid), 0);
        chk("reset_out", 32'(Out), 0);
        chk("reset_pending", Pending, 0);
        chk("reset_overrun", 32'(Overrun), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("idle_valid", 32'(Valid), 0);
            chk("idle_out", 32'(Out), 0);
            chk("idle_pending", Pending, 0);
            chk("idle_overrun", 32'(Overrun), 0);
        end

        // multi-hot pulse drained in priority order
        Ready = 1'b1;
        exp_q.push_back(5'd1); exp_q.push_back(5'd4); exp_q.push_back(5'd31);
        In = 32'h8000_0012;
        step(1); In = '0;
        chk("multi_valid", 32'(Valid), 1);
        chk("multi_pending", Pending, 32'h8000_0012);
        step(1);
        chk("multi_pending2", Pending, 32'h8000_0010);
        step(2);
        chk("multi_done_valid", 32'(Valid), 0);
        chk("multi_overrun", 32'(Overrun), 0);

        // re-request while pending, no consumer
        Ready = 1'b0;
        In = 32'h4; step(1); In = '0; step(1);
        In = 32'h4; step(1); In = '0;
        chk("ovf_set", 32'(Overrun), 1);
        chk("ovf_pending", Pending, 32'h4);
        exp_q.push_back(5'd2);
        Ready = 1'b1;
        step(1);
        chk("ovf_drained", 32'(Valid), 0);
        chk("ovf_sticky", 32'(Overrun), 1);
        ClearOvf = 1'b1; step(1); ClearOvf = 1'b0;
        chk("ovf_clear", 32'(Overrun), 0);

        // set wins over accept of the same bit
        Ready = 1'b0;
        In = 32'h8; step(1); In = '0;
        exp_q.push_back(5'd3); exp_q.push_back(5'd3);
        Ready = 1'b1; In = 32'h8;
        step(1); In = '0;
        chk("setwin_pending", Pending, 32'h8);
        step(1);
        chk("setwin_drained", Pending, 0);
        chk("setwin_overrun", 32'(Overrun), 0);

        // all lines at once: 32 back-to-back accepts
        pulse_reset();
        step(1);
        for (int i = 0; i < 32; i++) exp_q.push_back(5'(i));
        In = 32'hFFFF_FFFF;
        step(1); In = '0;
        for (int i = 0; i < 32; i++) begin
            chk("burst_valid", 32'(Valid), 1);
            step(1);
        end
        chk("burst_done_valid", 32'(Valid), 0);
        chk("burst_overrun", 32'(Overrun), 0);

        // asynchronous reset discards pending
        Ready = 1'b0;
        In = 32'h300; step(1); In = '0;
        chk("async_pre_pending", Pending, 32'h300);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(Valid), 0);
        chk("async_pending", Pending, 0);
        #1 reset_n = 1'b1;
        step(1);

`ifdef PENDING_ENCODER32_RR_EN
        In = 32'h11; step(1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(5'd0); exp_q.push_back(5'd4);
        end
        Ready = 1'b1;
        step(8);
        Ready = 1'b0; In = '0;
        pulse_reset();
        step(1);
`endif

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
